// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin is static low, static high, or a shared 8-bit PWM
// waveform whose duty is captured once per period so a period is never torn.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]    CNT_LAST   = 8'd254;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic [15:0]   out_q, out_d;
  logic          period_start_q, period_start_d;

  logic          tick;
  logic          start;
  logic [7:0]    duty_eff;
  logic          pwm;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // The start cycle already uses the live duty, so an update landing exactly
  // on the period boundary affects the very first step of that period.
  always_comb begin
    tick           = (presc_q == PRESC_LAST);
    start          = (presc_q == '0) && (cnt_q == 8'd0);
    presc_d        = tick ? '0 : presc_q + PW'(1);
    cnt_d          = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
    end
    duty_eff       = start ? pwm_duty_cycle : duty_q;
    duty_d         = duty_eff;
    pwm            = (duty_eff == 8'hFF) ? 1'b1 : (cnt_q < duty_eff);
    out_d          = en_out & (~en_pwm | {16{pwm}});
    period_start_d = start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= 8'd0;
      duty_q         <= 8'd0;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: a cycle-count based reference model
// plus per-scenario tasks that measure duty, period length and reset behaviour.
module tb_pwm_peripheral;

  localparam int DIV    = 2;
  localparam int PERIOD = 255 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int checks   = 0;
  int failures = 0;

  pwm_peripheral #(.CLK_DIV(DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  // Reference model: position in the period is derived purely from the number
  // of clock cycles elapsed since reset release.
  int          t;
  logic [7:0]  m_duty;
  logic [15:0] exp_out;
  logic        exp_ps;

  always @(posedge clk or negedge rst_n) begin
    int p;
    int stp;
    logic pw;
    if (!rst_n) begin
      t       = 0;
      m_duty  = 8'd0;
      exp_out = 16'h0000;
      exp_ps  = 1'b0;
    end else begin
      p   = t % PERIOD;
      stp = p / DIV;
      if (p == 0) m_duty = duty;
      pw      = (m_duty == 8'hFF) || (stp < int'(m_duty));
      exp_out = {eo_hi, eo_lo} & (~{ep_hi, ep_lo} | {16{pw}});
      exp_ps  = (p == 0);
      t       = t + 1;
    end
  end

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold out=%h ps=%b want out=0000 ps=0", out, period_start);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out !== 16'hFFFF || period_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_first out=%h ps=%b want out=ffff ps=1", out, period_start);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 16'hFFFF || period_start !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_after i=%0d out=%h ps=%b want out=ffff ps=0", i, out, period_start);
      end
    end
  endtask

  task automatic test_static();
    set_en(16'hA5F0, 16'h0000);
    @(negedge clk);
    checks++;
    if (out !== 16'hA5F0) begin
      failures++;
      $display("[TB] FAIL static_hi out=%h want a5f0", out);
    end
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h00;
    for (int i = 0; i < PERIOD + 1; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_out || period_start !== exp_ps) begin
        failures++;
        $display("[TB] FAIL static_model i=%0d out=%h want %h ps=%b want %b", i, out, exp_out, period_start, exp_ps);
      end
    end
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL static_duty0 out=%h want 0000", out);
    end
  endtask

  task automatic test_duty(input logic [7:0] d);
    bit ok;
    int high;
    int want;
    set_en(16'hFFFF, 16'hFFFF);
    duty = d;
    wait_ps(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL duty_timeout d=%h no period_start seen", d);
      return;
    end
    high = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out !== exp_out || period_start !== exp_ps) begin
        failures++;
        $display("[TB] FAIL duty_model d=%h i=%0d out=%h want %h ps=%b want %b", d, i, out, exp_out, period_start, exp_ps);
      end
      if (out[0] === 1'b1) high++;
    end
    want = (d == 8'hFF) ? PERIOD : int'(d) * DIV;
    checks++;
    if (high != want) begin
      failures++;
      $display("[TB] FAIL duty_high d=%h high=%0d want %0d", d, high, want);
    end
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL duty_period d=%h ps=%b want 1 after %0d cycles", d, period_start, PERIOD);
    end
  endtask

  task automatic test_glitch_free();
    bit ok;
    int high;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    wait_ps(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL glitch_timeout no period_start seen");
      return;
    end
    for (int per = 0; per < 2; per++) begin
      high = 0;
      for (int i = 0; i < PERIOD; i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (out !== exp_out || period_start !== exp_ps) begin
          failures++;
          $display("[TB] FAIL glitch_model per=%0d i=%0d out=%h want %h", per, i, out, exp_out);
        end
        if (out[0] === 1'b1) high++;
        if (per == 0 && i == 50) duty = 8'h20;
      end
      checks++;
      if (high != ((per == 0) ? 256 : 64)) begin
        failures++;
        $display("[TB] FAIL glitch_high per=%0d high=%0d want %0d", per, high, (per == 0) ? 256 : 64);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'hC0;
    wait_ps(ok);
    wait_ps(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL rstmid_timeout no period_start seen");
      return;
    end
    repeat (100 * DIV) @(negedge clk);
    checks++;
    if (out !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL rstmid_before out=%h want ffff", out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_async out=%h ps=%b want 0000/0", out, period_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out !== 16'hFFFF || period_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_restart out=%h ps=%b want ffff/1", out, period_start);
    end
    for (int i = 1; i < PERIOD; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_out || period_start !== exp_ps) begin
        failures++;
        $display("[TB] FAIL rstmid_model i=%0d out=%h want %h ps=%b want %b", i, out, exp_out, period_start, exp_ps);
      end
    end
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_period ps=%b want 1", period_start);
    end
  endtask

  task automatic test_mixed_pins();
    bit ok;
    bit saw0, saw1, bad_static;
    set_en(16'h00FF, 16'h000F);
    duty = 8'h80;
    wait_ps(ok);
    saw0 = 1'b0;
    saw1 = 1'b0;
    bad_static = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_out) begin
        failures++;
        $display("[TB] FAIL mixed_model i=%0d out=%h want %h", i, out, exp_out);
      end
      if (out[3:0] === 4'hF) saw1 = 1'b1;
      if (out[3:0] === 4'h0) saw0 = 1'b1;
      if (out[15:4] !== 12'h00F) bad_static = 1'b1;
    end
    checks++;
    if (!(saw0 && saw1) || bad_static) begin
      failures++;
      $display("[TB] FAIL mixed_pins saw0=%b saw1=%b bad_static=%b want 1 1 0", saw0, saw1, bad_static);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_out || period_start !== exp_ps) begin
        failures++;
        $display("[TB] FAIL random_model i=%0d out=%h want %h ps=%b want %b", i, out, exp_out, period_start, exp_ps);
      end
      if ($urandom_range(0, 60) == 0) duty = 8'($urandom);
      if ($urandom_range(0, 150) == 0) set_en(16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_en(16'h0000, 16'h0000);
    duty = 8'h00;
    test_reset();
    test_static();
    test_duty(8'h40);
    test_duty(8'hFF);
    test_duty(8'h01);
    test_duty(8'h00);
    test_duty(8'hFE);
    for (int k = 0; k < 3; k++) test_duty(8'($urandom_range(1, 254)));
    test_glitch_free();
    test_reset_mid();
    test_mixed_pins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Consumes the five configuration registers produced by the SPI register block and drives 16 output pins. Each pin is either static low, static high, or a shared 8-bit PWM waveform, selected by the output-enable and PWM-enable bytes. Duty-cycle updates are double-buffered so that a waveform period is never torn. The block sits directly downstream of the SPI register file and feeds the chip's output pads.

## Interface
Parameters:
- CLK_DIV, default 13: clk cycles per PWM count step; must be ≥1. With a 10 MHz clk and 255 steps, PWM frequency is ≈3.0 kHz.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- en_reg_out_7_0  input  8  output enable for pins 7..0.
- en_reg_out_15_8  input  8  output enable for pins 15..8.
- en_reg_pwm_7_0  input  8  PWM mode select for pins 7..0.
- en_reg_pwm_15_8  input  8  PWM mode select for pins 15..8.
- pwm_duty_cycle  input  8  duty, 0x00 = 0%, 0xFF = 100%.
- out  output  16  pin drive; bit i maps to enable bit i of the concatenated {15_8, 7_0} bytes.
- period_start  output  1  one-cycle pulse in the first clk cycle of each PWM period.

## Operation
- The input registers are treated as quasi-static, in the clk domain. The block adds no synchroniser.
- Prescaler `presc`:
  - counts 0..CLK_DIV-1 and wraps to 0;
  - `tick` = (presc == CLK_DIV-1). With CLK_DIV=1, tick is high every cycle.
- Step counter `cnt`:
  - 8-bit, counts 0..254 and advances on tick;
  - on a tick at 254 it wraps to 0, so a period is 255 steps = 255·CLK_DIV clk cycles;
  - never reaches 255.
- Period start condition: `start` = (presc == 0 && cnt == 0). This includes the first cycle after reset.
- Duty shadow register `duty_q`:
  - loads pwm_duty_cycle in every start cycle and holds it otherwise;
  - effective duty `duty_eff` = start ? pwm_duty_cycle : duty_q, so the first step of a period already uses the new value.
- PWM signal: `pwm` = (duty_eff == 8'hFF) ? 1 : (cnt < duty_eff). This is an unsigned 8-bit compare.
  - 0x00 gives constant low;
  - 0xFF gives constant high;
  - duty d in 1..254 gives high for exactly d·CLK_DIV cycles per period.
- Per-pin selection, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i]=0 → 0, regardless of en_pwm;
  - en_out[i]=1, en_pwm[i]=0 → 1;
  - en_out[i]=1, en_pwm[i]=1 → pwm.
- All pins in PWM mode share one waveform and are phase-aligned.
- Enable changes are not period-synchronised; they take effect on the next clk edge.

## Timing
- Reset (rst_n low, asynchronous):
  - presc=0, cnt=0, duty_q=0;
  - out=16'h0000, period_start=0.
- out and period_start are registered. The value computed from presc/cnt/inputs in cycle N appears after the clk edge that ends cycle N.
- period_start rises one cycle after the start condition and is high for exactly one cycle per period.
- Latencies:
  - enable change → out: 1 cycle;
  - duty change → out: at the next period start, plus 1 cycle.
- A duty change in the same cycle as start is taken. A change one cycle after start waits a full period.
- Reset asserted mid-period: outputs go low immediately. After release, the counter restarts at presc=0, cnt=0, and the first cycle is a start cycle using the live duty.
- Simultaneous tick and wrap at cnt=254: cnt←0 and presc←0 on the same edge. The next cycle is a start cycle.

## Test plan
- Reset/defaults: hold rst_n low with all inputs 0xFF → out=16'h0000, period_start=0. Release rst_n → out=16'hFFFF from cycle 2 onward.
- Static modes: en_out=16'hA5F0, en_pwm=16'h0000 → out=16'hA5F0 one cycle later. Then en_pwm=16'hFFFF with duty=0 → out=16'h0000.
- Duty accuracy, CLK_DIV=2, duty=0x40, en_out=en_pwm=16'hFFFF:
  - per period, out high 128 cycles, low 382;
  - period_start pulses every 510 cycles.
  - Repeat with duty=0xFF → constant 16'hFFFF; duty=0x01 → high for 2 cycles per period.
- Glitch-free update: change duty 0x80→0x20 mid-period → the current period completes with 256 high cycles (CLK_DIV=2), and the next period has 64 high cycles.
- Async reset mid-period: pulse rst_n low for 3 cycles at cnt=100 → out=0 immediately. The first period_start occurs one cycle after release, and a full period follows.
- Mixed pins: en_out=16'h00FF, en_pwm=16'h000F, duty=0x80 → pins 3..0 toggle, pins 7..4 are constant 1, and pins 15..8 are constant 0.
